// File: rtl/wb_arbiter2_pkg.sv
// Shared constants and types for the two-master Wishbone arbiter.
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_ERRW = 2'd3
  } arb_state_e;

  localparam int unsigned TO_CNT_W = 16;

  localparam logic LAST_M0 = 1'b0;
  localparam logic LAST_M1 = 1'b1;

endpackage

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with a locked grant per bus cycle
// and a slave-ack timeout that returns a one-cycle bus error.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_sel,
  input  logic            m0_we,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_ack,
  output logic            m0_err,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_sel,
  input  logic            m1_we,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_sel,
  output logic            s_we,
  output logic            s_cyc,
  output logic            s_stb,
  input  logic [DW-1:0]   s_rdata,
  input  logic            s_ack
);

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT);
  localparam logic [TO_CNT_W-1:0] CNT_ONE  = {{(TO_CNT_W-1){1'b0}}, 1'b1};

  arb_state_e          state_r;
  arb_state_e          state_s;
  logic                last_r;
  logic [TO_CNT_W-1:0] cnt_r;
  logic                own_cyc_s;
  logic                own_stb_s;
  logic                owning_s;
  logic                timeout_s;

  // Owner's cyc/stb; in ERRW the errored master is the last one granted
  always_comb begin
    own_cyc_s = 1'b0;
    own_stb_s = 1'b0;
    case (state_r)
      ST_OWN0: begin own_cyc_s = m0_cyc; own_stb_s = m0_stb; end
      ST_OWN1: begin own_cyc_s = m1_cyc; own_stb_s = m1_stb; end
      ST_ERRW: begin own_cyc_s = (last_r == LAST_M1) ? m1_cyc : m0_cyc; own_stb_s = 1'b0; end
      default: begin own_cyc_s = 1'b0; own_stb_s = 1'b0; end
    endcase
  end

  // A same-cycle ack beats the timeout
  assign owning_s  = (state_r == ST_OWN0) || (state_r == ST_OWN1);
  assign timeout_s = owning_s && own_cyc_s && !s_ack && (cnt_r == TO_LIMIT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: round-robin on ties, grant held while the owner keeps cyc
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (m0_cyc && m1_cyc) begin
          state_s = (last_r == LAST_M1) ? ST_OWN0 : ST_OWN1;
        end else if (m0_cyc) begin
          state_s = ST_OWN0;
        end else if (m1_cyc) begin
          state_s = ST_OWN1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_cyc_s) begin
          state_s = ST_IDLE;
        end else if (timeout_s) begin
          state_s = ST_ERRW;
        end else begin
          state_s = state_r;
        end
      end
      ST_ERRW: begin
        if (!own_cyc_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ERRW;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Last-granted master, updated only when leaving IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r <= LAST_M1;
    end else if ((state_r == ST_IDLE) && (state_s == ST_OWN0)) begin
      last_r <= LAST_M0;
    end else if ((state_r == ST_IDLE) && (state_s == ST_OWN1)) begin
      last_r <= LAST_M1;
    end
  end

  // Stall counter for the ack timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if ((state_r == ST_IDLE) || s_ack || (state_s != state_r)) begin
      cnt_r <= '0;
    end else if (owning_s && own_stb_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Output mux; reset masks every strobe and response combinationally
  always_comb begin
    s_addr  = m0_addr;
    s_wdata = m0_wdata;
    s_sel   = {(DW/8){1'b0}};
    s_we    = 1'b0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    m0_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_ack  = 1'b0;
    m1_err  = 1'b0;
    case (state_r)
      ST_OWN0: begin
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_sel   = m0_sel;
        s_we    = m0_we;
        s_cyc   = m0_cyc & ~timeout_s & ~reset;
        s_stb   = m0_stb & ~timeout_s & ~reset;
        m0_ack  = s_ack & ~reset;
        m0_err  = timeout_s & ~reset;
      end
      ST_OWN1: begin
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_sel   = m1_sel;
        s_we    = m1_we;
        s_cyc   = m1_cyc & ~timeout_s & ~reset;
        s_stb   = m1_stb & ~timeout_s & ~reset;
        m1_ack  = s_ack & ~reset;
        m1_err  = timeout_s & ~reset;
      end
      default: begin
        s_cyc = 1'b0;
        s_stb = 1'b0;
      end
    endcase
  end

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed self-checking bench for wb_arbiter2 (TIMEOUT=4).
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
  logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_we, s_cyc, s_stb, s_ack;

  int checks = 0;
  int errors = 0;

  wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel), .s_we(s_we),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_rdata(s_rdata), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_drive(input logic cyc, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel);
    m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_sel = sel;
  endtask

  task automatic m1_drive(input logic cyc, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel);
    m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_sel = sel;
  endtask

  initial begin
    reset = 1'b1; s_ack = 1'b0; s_rdata = 32'h0;
    m0_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    m1_drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state
    tick(); #2;
    chk("rst_s_cyc", s_cyc, 1'b0); chk("rst_s_stb", s_stb, 1'b0);
    chk("rst_m0_ack", m0_ack, 1'b0); chk("rst_m1_err", m1_err, 1'b0);
    tick(); reset = 1'b0; #2;
    chk("post_rst_s_cyc", s_cyc, 1'b0);

    // Single m0 read, slave acks two cycles after stb
    tick(); m0_drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hf); #2;
    chk("rd_idle_s_cyc", s_cyc, 1'b0);
    tick(); #2;
    chk("rd_s_cyc", s_cyc, 1'b1); chk("rd_s_stb", s_stb, 1'b1);
    chk("rd_s_addr", s_addr, 32'h0000_0010); chk("rd_m0_ack_early", m0_ack, 1'b0);
    tick(); #2;
    chk("rd_m0_ack_wait", m0_ack, 1'b0);
    tick(); s_ack = 1'b1; s_rdata = 32'hCAFE_F00D; #2;
    chk("rd_m0_ack", m0_ack, 1'b1); chk("rd_m0_rdata", m0_rdata, 32'hCAFE_F00D);
    chk("rd_m1_ack", m1_ack, 1'b0); chk("rd_m0_err", m0_err, 1'b0);
    tick(); s_ack = 1'b0; m0_drive(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'hf); #2;
    chk("rd_m0_ack_once", m0_ack, 1'b0); chk("rd_s_cyc_drop", s_cyc, 1'b0);
    tick();

    // Round-robin after a fresh reset
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    m0_drive(1'b1, 1'b0, 32'h100, 32'h0, 4'hf);
    m1_drive(1'b1, 1'b0, 32'h200, 32'h0, 4'hf); #2;
    chk("rr_idle_s_cyc", s_cyc, 1'b0);
    tick(); s_ack = 1'b1; #2;
    chk("rr1_s_addr", s_addr, 32'h100); chk("rr1_s_cyc", s_cyc, 1'b1);
    chk("rr1_m0_ack", m0_ack, 1'b1); chk("rr1_m1_ack", m1_ack, 1'b0);
    tick(); s_ack = 1'b0; m0_drive(1'b0, 1'b0, 32'h100, 32'h0, 4'hf); #2;
    chk("rr1_drop_s_cyc", s_cyc, 1'b0);
    tick(); #2;
    chk("rr1_idle_s_cyc", s_cyc, 1'b0);
    tick(); s_ack = 1'b1; m0_drive(1'b1, 1'b0, 32'h104, 32'h0, 4'hf); #2;
    chk("rr2_s_addr", s_addr, 32'h200); chk("rr2_m1_ack", m1_ack, 1'b1);
    chk("rr2_m0_ack", m0_ack, 1'b0);
    tick(); s_ack = 1'b0; m1_drive(1'b0, 1'b0, 32'h200, 32'h0, 4'hf);
    tick(); m1_drive(1'b1, 1'b0, 32'h204, 32'h0, 4'hf); #2;
    chk("rr3_idle_s_cyc", s_cyc, 1'b0);
    tick(); s_ack = 1'b1; #2;
    chk("rr3_s_addr", s_addr, 32'h104); chk("rr3_m0_ack", m0_ack, 1'b1);
    chk("rr3_m1_ack", m1_ack, 1'b0);
    tick(); s_ack = 1'b0; m0_drive(1'b0, 1'b0, 32'h104, 32'h0, 4'hf);
    tick();
    tick(); s_ack = 1'b1; #2;
    chk("rr4_s_addr", s_addr, 32'h204); chk("rr4_m1_ack", m1_ack, 1'b1);
    tick(); s_ack = 1'b0; m1_drive(1'b0, 1'b0, 32'h204, 32'h0, 4'hf);
    tick();

    // m1 write locked against a competing m0 request
    m1_drive(1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0011); #2;
    chk("wr_idle_s_cyc", s_cyc, 1'b0);
    tick(); m0_drive(1'b1, 1'b0, 32'h400, 32'h0, 4'hf); #2;
    chk("wr_s_addr", s_addr, 32'h300); chk("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("wr_s_sel", s_sel, 4'b0011); chk("wr_s_we", s_we, 1'b1); chk("wr_s_cyc", s_cyc, 1'b1);
    tick(); s_ack = 1'b1; #2;
    chk("wr_m1_ack", m1_ack, 1'b1); chk("wr_m0_ack", m0_ack, 1'b0);
    tick(); s_ack = 1'b0; m1_drive(1'b1, 1'b1, 32'h304, 32'hDEAD_BEEF, 4'b0011); #2;
    chk("wr_beat2_s_addr", s_addr, 32'h304);
    tick(); m1_drive(1'b0, 1'b0, 32'h304, 32'h0, 4'b0011); #2;
    chk("wr_drop_s_cyc", s_cyc, 1'b0);
    tick(); #2;
    chk("wr_idle2_s_cyc", s_cyc, 1'b0);
    tick(); s_ack = 1'b1; #2;
    chk("wr_m0_s_addr", s_addr, 32'h400); chk("wr_m0_s_we", s_we, 1'b0);
    chk("wr_m0_ack", m0_ack, 1'b1);
    tick(); s_ack = 1'b0; m0_drive(1'b0, 1'b0, 32'h400, 32'h0, 4'hf);
    tick();

    // Timeout: four stalled cycles then a single err pulse
    m0_drive(1'b1, 1'b0, 32'h500, 32'h0, 4'hf); #2;
    chk("to_idle_s_cyc", s_cyc, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); #2;
      chk("to_stall_s_cyc", s_cyc, 1'b1); chk("to_stall_m0_err", m0_err, 1'b0);
    end
    tick(); #2;
    chk("to_m0_err", m0_err, 1'b1); chk("to_s_cyc", s_cyc, 1'b0);
    chk("to_s_stb", s_stb, 1'b0); chk("to_m0_ack", m0_ack, 1'b0);
    tick(); s_ack = 1'b1; #2;
    chk("errw_m0_err", m0_err, 1'b0); chk("errw_m0_ack", m0_ack, 1'b0);
    chk("errw_s_cyc", s_cyc, 1'b0);
    tick(); s_ack = 1'b0; m0_drive(1'b0, 1'b0, 32'h500, 32'h0, 4'hf); #2;
    chk("errw_drop_s_cyc", s_cyc, 1'b0);
    tick(); m1_drive(1'b1, 1'b0, 32'h600, 32'h0, 4'hf); #2;
    chk("errw_idle_s_cyc", s_cyc, 1'b0);
    tick(); #2;
    chk("errw_next_s_cyc", s_cyc, 1'b1); chk("errw_next_s_addr", s_addr, 32'h600);
    tick(); m1_drive(1'b0, 1'b0, 32'h600, 32'h0, 4'hf);
    tick();

    // Ack on the timeout cycle wins over the error
    m0_drive(1'b1, 1'b0, 32'h700, 32'h0, 4'hf);
    for (int i = 0; i < 4; i++) tick();
    tick(); s_ack = 1'b1; s_rdata = 32'h1234_5678; #2;
    chk("tack_m0_ack", m0_ack, 1'b1); chk("tack_m0_err", m0_err, 1'b0);
    chk("tack_s_cyc", s_cyc, 1'b1); chk("tack_m0_rdata", m0_rdata, 32'h1234_5678);
    tick(); s_ack = 1'b0; m0_drive(1'b0, 1'b0, 32'h700, 32'h0, 4'hf); #2;
    chk("tack_after_m0_err", m0_err, 1'b0);
    tick();

    // Reset while m1 owns the bus
    m1_drive(1'b1, 1'b0, 32'h800, 32'h0, 4'hf);
    tick(); #2;
    chk("rs_own1_s_cyc", s_cyc, 1'b1); chk("rs_own1_s_addr", s_addr, 32'h800);
    tick(); reset = 1'b1; s_ack = 1'b1; #2;
    chk("rs_s_cyc", s_cyc, 1'b0); chk("rs_m1_ack", m1_ack, 1'b0); chk("rs_m1_err", m1_err, 1'b0);
    tick(); reset = 1'b0; s_ack = 1'b0; m0_drive(1'b1, 1'b0, 32'h900, 32'h0, 4'hf); #2;
    chk("rs_idle_s_cyc", s_cyc, 1'b0);
    tick(); s_ack = 1'b1; m0_drive(1'b0, 1'b0, 32'h900, 32'h0, 4'hf); #2;
    chk("rs_m0_ack_drop", m0_ack, 1'b1); chk("rs_m1_ack", m1_ack, 1'b0);
    tick(); s_ack = 1'b0; #2;
    chk("rs_idle2_s_cyc", s_cyc, 1'b0);
    tick(); #2;
    chk("rs_m1_s_cyc", s_cyc, 1'b1); chk("rs_m1_s_addr", s_addr, 32'h800);
    tick(); m1_drive(1'b0, 1'b0, 32'h800, 32'h0, 4'hf);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
